// File: rtl/vram_write_arbiter_if.sv
// Write-port bundle between the CPU/keyboard requesters, the clear trigger and the VRAM
// arbiter. The master side drives requests; the slave side is the arbiter.
interface vram_write_arbiter_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned COLOR_W = 3
);
  logic               cpu_req;
  logic [15:0]        cpu_row;
  logic [15:0]        cpu_col;
  logic [COLOR_W-1:0] cpu_color;
  logic               cpu_ack;

  logic               kbd_req;
  logic [15:0]        kbd_row;
  logic [15:0]        kbd_col;
  logic [COLOR_W-1:0] kbd_color;
  logic               kbd_ack;

  logic               clear_start;
  logic               busy;
  logic               clear_done;
  logic               oob;

  logic               vram_we;
  logic [ADDR_W-1:0]  vram_addr;
  logic [COLOR_W-1:0] vram_data;

  modport master (
    output cpu_req, cpu_row, cpu_col, cpu_color,
    output kbd_req, kbd_row, kbd_col, kbd_color,
    output clear_start,
    input  cpu_ack, kbd_ack, busy, clear_done, oob,
    input  vram_we, vram_addr, vram_data
  );

  modport slave (
    input  cpu_req, cpu_row, cpu_col, cpu_color,
    input  kbd_req, kbd_row, kbd_col, kbd_color,
    input  clear_start,
    output cpu_ack, kbd_ack, busy, clear_done, oob,
    output vram_we, vram_addr, vram_data
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Single-port VRAM write arbiter: round-robin between CPU and keyboard writes, with a
// full-screen clear engine that takes the port exclusively while it runs.
module vram_write_arbiter #(
  parameter int unsigned        COLS      = 16,
  parameter int unsigned        ROWS      = 16,
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        COLOR_W   = 3,
  parameter logic [COLOR_W-1:0] CLR_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  vram_write_arbiter_if.slave bus
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(CELLS + 1);
  localparam logic [15:0] ROWS_C = 16'(ROWS);
  localparam logic [15:0] COLS_C = 16'(COLS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;
  logic               kbd_last;

  logic               cpu_elig;
  logic               kbd_elig;
  logic               grant;
  logic               pick_cpu;
  logic [15:0]        sel_row;
  logic [15:0]        sel_col;
  logic [COLOR_W-1:0] sel_color;
  logic               in_range;
  logic [ADDR_W-1:0]  sel_addr;

  // A requester whose ack is showing this cycle is still holding the request it was just
  // granted, so it is masked until the ack drops.
  assign cpu_elig = bus.cpu_req & ~bus.cpu_ack;
  assign kbd_elig = bus.kbd_req & ~bus.kbd_ack;
  assign grant    = cpu_elig | kbd_elig;
  assign pick_cpu = cpu_elig & (~kbd_elig | kbd_last);

  assign sel_row   = pick_cpu ? bus.cpu_row   : bus.kbd_row;
  assign sel_col   = pick_cpu ? bus.cpu_col   : bus.kbd_col;
  assign sel_color = pick_cpu ? bus.cpu_color : bus.kbd_color;

  // Range test at full coordinate width, so the truncated product below can never alias.
  assign in_range = (sel_row < ROWS_C) && (sel_col < COLS_C);
  assign sel_addr = ADDR_W'(sel_row) * ADDR_W'(COLS) + ADDR_W'(sel_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      clr_cnt        <= '0;
      kbd_last       <= 1'b1;
      bus.cpu_ack    <= 1'b0;
      bus.kbd_ack    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.oob        <= 1'b0;
      bus.vram_we    <= 1'b0;
      bus.vram_addr  <= '0;
      bus.vram_data  <= '0;
    end else begin
      bus.cpu_ack    <= 1'b0;
      bus.kbd_ack    <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.oob        <= 1'b0;
      bus.vram_we    <= 1'b0;
      bus.vram_addr  <= '0;
      bus.vram_data  <= '0;

      case (state)
        S_IDLE: begin
          if (bus.clear_start) begin
            // First clear write goes out together with busy; requests stay pending.
            state         <= S_CLEAR;
            bus.busy      <= 1'b1;
            bus.vram_we   <= 1'b1;
            bus.vram_addr <= '0;
            bus.vram_data <= CLR_COLOR;
            clr_cnt       <= CNT_W'(1);
          end else if (grant) begin
            bus.cpu_ack <= pick_cpu;
            bus.kbd_ack <= ~pick_cpu;
            kbd_last    <= ~pick_cpu;
            if (in_range) begin
              bus.vram_we   <= 1'b1;
              bus.vram_addr <= sel_addr;
              bus.vram_data <= sel_color;
            end else begin
              bus.oob <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          if (clr_cnt == CNT_W'(CELLS)) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.clear_done <= 1'b1;
            clr_cnt        <= '0;
          end else begin
            bus.vram_we   <= 1'b1;
            bus.vram_addr <= ADDR_W'(clr_cnt);
            bus.vram_data <= CLR_COLOR;
            clr_cnt       <= clr_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          clr_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized bench for vram_write_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_vram_write_arbiter;

  localparam int unsigned COLS  = 16;
  localparam int unsigned ROWS  = 16;
  localparam int unsigned CELLS = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_write_arbiter_if bus ();

  vram_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [2:0] data;
    logic       cpu_ack;
    logic       kbd_ack;
    logic       oob;
    logic       busy;
    logic       clear_done;
  } out_t;

  out_t exp_cur = '0;
  out_t nxt_m;
  out_t sched[$];
  bit   armed     = 1'b0;
  bit   prev_kbd  = 1'b1;
  bit   ce_m;
  bit   ke_m;
  int   n_tests   = 0;
  int   n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: one serviced request, laid out as the port should show it.
  function automatic out_t serve(input bit is_cpu, input logic [15:0] row,
                                 input logic [15:0] col, input logic [2:0] color);
    out_t o = '0;
    o.cpu_ack = is_cpu;
    o.kbd_ack = !is_cpu;
    if (32'(row) < ROWS && 32'(col) < COLS) begin
      o.we   = 1'b1;
      o.addr = 8'(32'(row) * COLS + 32'(col));
      o.data = color;
    end else begin
      o.oob = 1'b1;
    end
    return o;
  endfunction

  // Reference: a clear is a fixed script of CELLS writes followed by the done pulse.
  function automatic void queue_clear();
    out_t w;
    for (int a = 0; a < int'(CELLS); a++) begin
      w      = '0;
      w.we   = 1'b1;
      w.addr = 8'(a);
      w.busy = 1'b1;
      sched.push_back(w);
    end
    w            = '0;
    w.clear_done = 1'b1;
    sched.push_back(w);
  endfunction

  // Compare this cycle, then predict the next one from the inputs the DUT will sample.
  always @(negedge clk) begin
    if (armed) begin
      check("we",         32'(bus.vram_we),    32'(exp_cur.we));
      check("addr",       32'(bus.vram_addr),  32'(exp_cur.addr));
      check("data",       32'(bus.vram_data),  32'(exp_cur.data));
      check("cpu_ack",    32'(bus.cpu_ack),    32'(exp_cur.cpu_ack));
      check("kbd_ack",    32'(bus.kbd_ack),    32'(exp_cur.kbd_ack));
      check("oob",        32'(bus.oob),        32'(exp_cur.oob));
      check("busy",       32'(bus.busy),       32'(exp_cur.busy));
      check("clear_done", 32'(bus.clear_done), 32'(exp_cur.clear_done));
    end
    nxt_m = '0;
    if (rst) begin
      sched.delete();
      prev_kbd = 1'b1;
      armed    = 1'b1;
    end else if (armed) begin
      if (sched.size() > 0) begin
        nxt_m = sched.pop_front();
      end else if (bus.clear_start) begin
        queue_clear();
        nxt_m = sched.pop_front();
      end else begin
        ce_m = bus.cpu_req && !exp_cur.cpu_ack;
        ke_m = bus.kbd_req && !exp_cur.kbd_ack;
        if (ce_m && (!ke_m || prev_kbd)) begin
          nxt_m    = serve(1'b1, bus.cpu_row, bus.cpu_col, bus.cpu_color);
          prev_kbd = 1'b0;
        end else if (ke_m) begin
          nxt_m    = serve(1'b0, bus.kbd_row, bus.kbd_col, bus.kbd_color);
          prev_kbd = 1'b1;
        end
      end
    end
    exp_cur = nxt_m;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_coord();
    logic [15:0] c;
    case ($urandom_range(0, 9))
      0:       c = 16'd16;
      1:       c = 16'hFFFF;
      2:       c = 16'($urandom);
      default: c = 16'($urandom_range(0, 15));
    endcase
    return c;
  endfunction

  task automatic new_cpu();
    bus.cpu_req   = 1'b1;
    bus.cpu_row   = rand_coord();
    bus.cpu_col   = rand_coord();
    bus.cpu_color = 3'($urandom);
  endtask

  task automatic new_kbd();
    bus.kbd_req   = 1'b1;
    bus.kbd_row   = rand_coord();
    bus.kbd_col   = rand_coord();
    bus.kbd_color = 3'($urandom);
  endtask

  int  busy_cycles;
  int  next_addr;
  bit  done;
  bit  found;

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_row = '0; bus.cpu_col = '0; bus.cpu_color = '0;
    bus.kbd_req = 1'b0; bus.kbd_row = '0; bus.kbd_col = '0; bus.kbd_color = '0;
    bus.clear_start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'({bus.vram_we, bus.vram_addr, bus.vram_data, bus.cpu_ack,
                                bus.kbd_ack, bus.oob, bus.busy, bus.clear_done}), 0);

    // Single CPU write, then the held request must not be regranted.
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_row = 16'd2; bus.cpu_col = 16'd3; bus.cpu_color = 3'b010;
    tick();
    check("t1_we",   32'(bus.vram_we),   1);
    check("t1_addr", 32'(bus.vram_addr), 35);
    check("t1_data", 32'(bus.vram_data), 32'b010);
    check("t1_ack",  32'(bus.cpu_ack),   1);
    tick();
    check("t1_no_regrant", 32'({bus.cpu_ack, bus.vram_we}), 0);
    bus.cpu_req = 1'b0;
    tick();

    // Both requesting from reset: strict alternation starting with CPU.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_row = 16'd1; bus.cpu_col = 16'd1; bus.cpu_color = 3'd1;
    bus.kbd_req = 1'b1; bus.kbd_row = 16'd5; bus.kbd_col = 16'd7; bus.kbd_color = 3'd6;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_cpu_ack", 32'(bus.cpu_ack), 32'(i % 2 == 0));
      check("t2_kbd_ack", 32'(bus.kbd_ack), 32'(i % 2 == 1));
      check("t2_we",      32'(bus.vram_we), 1);
    end
    bus.cpu_req = 1'b0; bus.kbd_req = 1'b0;
    repeat (2) tick();

    // Full clear, a keyboard request raised mid-clear and a restart attempt that is ignored.
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    busy_cycles = 0; next_addr = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.clear_done) begin
        done = 1'b1;
      end else begin
        if (bus.busy) busy_cycles++;
        if (bus.vram_we && int'(bus.vram_addr) == next_addr && bus.vram_data == 3'b000)
          next_addr++;
        if (bus.kbd_ack) check("t4_ack_in_clear", 32'(bus.kbd_ack), 0);
        if (i == 50) begin
          bus.kbd_req = 1'b1; bus.kbd_row = 16'd4; bus.kbd_col = 16'd9; bus.kbd_color = 3'd5;
        end
        bus.clear_start = (i == 100);
        tick();
      end
    end
    bus.clear_start = 1'b0;
    check("t3_done_seen",   32'(done),        1);
    check("t3_busy_cycles", 32'(busy_cycles), CELLS);
    check("t3_addr_seq",    32'(next_addr),   CELLS);
    check("t4_ack_at_done", 32'({bus.kbd_ack, bus.busy}), 0);
    tick();
    check("t4_ack_after",  32'(bus.kbd_ack),   1);
    check("t4_we_after",   32'(bus.vram_we),   1);
    check("t4_addr_after", 32'(bus.vram_addr), 73);
    bus.kbd_req = 1'b0;
    tick();

    // Out-of-range coordinates: ack and oob without a write.
    bus.cpu_req = 1'b1; bus.cpu_row = 16'd16; bus.cpu_col = 16'd0; bus.cpu_color = 3'd7;
    tick();
    check("t5_row16", 32'({bus.cpu_ack, bus.oob, bus.vram_we}), 32'b110);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_row = 16'd0; bus.cpu_col = 16'hFFFF;
    tick();
    check("t5_colffff", 32'({bus.cpu_ack, bus.oob, bus.vram_we}), 32'b110);
    bus.cpu_req = 1'b0;
    tick();

    // Reset in the middle of a clear aborts it; the port then serves a request normally.
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.vram_we && bus.vram_addr == 8'd100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t6_reached_100", 32'(found), 1);
    rst = 1'b1;
    tick();
    check("t6_rst_outputs", 32'({bus.vram_we, bus.vram_addr, bus.vram_data, bus.cpu_ack,
                                 bus.kbd_ack, bus.oob, bus.busy, bus.clear_done}), 0);
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_row = 16'd15; bus.cpu_col = 16'd15; bus.cpu_color = 3'd5;
    tick();
    check("t6_served_ack",  32'(bus.cpu_ack),   1);
    check("t6_served_addr", 32'(bus.vram_addr), 255);
    bus.cpu_req = 1'b0;
    repeat (4) tick();

    // Random traffic: requesters follow the hold-until-ack protocol; clears and resets sprinkled.
    for (int c = 0; c < 4000; c++) begin
      if (bus.cpu_req && bus.cpu_ack) begin
        if ($urandom_range(0, 2) == 0) new_cpu();
        else bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        new_cpu();
      end
      if (bus.kbd_req && bus.kbd_ack) begin
        if ($urandom_range(0, 2) == 0) new_kbd();
        else bus.kbd_req = 1'b0;
      end else if (!bus.kbd_req && $urandom_range(0, 2) == 0) begin
        new_kbd();
      end
      bus.clear_start = ($urandom_range(0, 299) == 0);
      rst             = ($urandom_range(0, 599) == 0);
      tick();
    end

    rst = 1'b0;
    bus.clear_start = 1'b0;
    bus.cpu_req = 1'b0;
    bus.kbd_req = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
